// File: rtl/nx_ram_pkg.sv
// Shared types and limits for the nx_ram family: init-sequencer states
// and the legal read-latency range.
package nx_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } init_state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;

endpackage

// File: rtl/nx_ram_init_fsm.sv
// Clear sequencer: after reset (or an init_start in DONE) it walks every
// word address once, ascending, asking the array to store the init word.
module nx_ram_init_fsm
  import nx_ram_pkg::*;
#(
  parameter int DEPTH = 168,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_start,
  output init_state_e   state,
  output logic [AW-1:0] clear_addr,
  output logic          clear_we
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // State, clear address and clear strobe advance together so the strobe is a plain flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clear_addr <= '0;
      clear_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= CLEAR;
          clear_addr <= '0;
          clear_we   <= 1'b1;
        end
        CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            state    <= DONE;
            clear_we <= 1'b0;
          end else begin
            clear_addr <= clear_addr + AW'(1);
          end
        end
        DONE: begin
          if (init_start) begin
            state      <= CLEAR;
            clear_addr <= '0;
            clear_we   <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          clear_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nx_ram_1r1w_init.sv
// One-read/one-write RAM with a built-in clear sequencer, bit-granular
// write enables, a configurable-latency read pipeline and range checking.
module nx_ram_1r1w_init
  import nx_ram_pkg::*;
#(
  parameter int               WIDTH        = 83,
  parameter int               DEPTH        = 168,
  parameter int               RD_LATENCY   = 1,
  parameter bit               WRITETHROUGH = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
  localparam int              AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  output logic             init_busy,
  output logic             init_done,
  input  logic             reb,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             web,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] bwe,
  output logic             addr_err
);

  if (WIDTH < 1 || WIDTH > 512) begin : g_bad_width
    $error("nx_ram_1r1w_init: WIDTH=%0d outside 1..512", WIDTH);
  end
  if (DEPTH < 2 || DEPTH > 4096) begin : g_bad_depth
    $error("nx_ram_1r1w_init: DEPTH=%0d outside 2..4096", DEPTH);
  end
  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_lat
    $error("nx_ram_1r1w_init: RD_LATENCY=%0d outside %0d..%0d",
           RD_LATENCY, RD_LATENCY_MIN, RD_LATENCY_MAX);
  end

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  init_state_e state;
  logic [AW-1:0] clear_addr;
  logic          clear_we;

  nx_ram_init_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_fsm (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .state      (state),
    .clear_addr (clear_addr),
    .clear_we   (clear_we)
  );

  assign init_busy = (state == CLEAR);
  assign init_done = (state == DONE);

  logic rd_acc, wr_acc, rd_in_range, wr_in_range;
  assign rd_acc      = init_done && !reb;
  assign wr_acc      = init_done && !web;
  assign rd_in_range = ({1'b0, ra} < DEPTH_W);
  assign wr_in_range = ({1'b0, wa} < DEPTH_W);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_vld;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_din, wr_bwe;
  logic             wr_commit;
  logic [WIDTH-1:0] wr_merged;

  assign wr_commit = wr_vld && ({1'b0, wr_addr} < DEPTH_W);
  assign wr_merged = (mem[wr_addr] & ~wr_bwe) | (wr_din & wr_bwe);

  // Write stage: hold an accepted write for one cycle so it commits on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld <= 1'b0;
    end else begin
      wr_vld  <= wr_acc;
      wr_addr <= wa;
      wr_din  <= din;
      wr_bwe  <= bwe;
    end
  end

  // Array update: the clear sequencer owns the port while it runs; contents are never reset.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= INIT_VALUE;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  logic [WIDTH-1:0] rd_word;

  // Read word as seen before this edge's commit, optionally bypassing the committing write.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (WRITETHROUGH && wr_commit && (wr_addr == ra)) begin
        rd_word = wr_merged;
      end else begin
        rd_word = mem[ra];
      end
    end
  end

  logic [RD_LATENCY-1:0]            pipe_vld;
  logic [RD_LATENCY-1:0][WIDTH-1:0] pipe_data;

  // Read pipeline: each stage only loads on a valid beat so the final stage holds dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_data <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) begin
        pipe_data[0] <= rd_word;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

  assign dout     = pipe_data[RD_LATENCY-1];
  assign dout_vld = pipe_vld[RD_LATENCY-1];

  // Range error: a single pulse for any accepted access beyond the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (rd_acc && !rd_in_range) || (wr_acc && !wr_in_range);
    end
  end

endmodule

// File: tb/tb_nx_ram_1r1w_init.sv
// Bench for nx_ram_1r1w_init: two instances share one stimulus stream,
// A (write-old, latency 1, zero init) and B (write-through, latency 3,
// non-zero init), both checked every cycle against a behavioural model.
module tb_nx_ram_1r1w_init;

  localparam int W = 83;
  localparam int D = 168;
  localparam logic [W-1:0] INIT_B = 83'h5DEADBEEF0123456789AB;
  localparam logic [W-1:0] ONES   = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         init_start;
  logic         reb, web;
  logic [7:0]   ra, wa;
  logic [W-1:0] din, bwe;

  logic         a_busy, a_done, a_vld, a_err;
  logic [W-1:0] a_dout;
  logic         b_busy, b_done, b_vld, b_err;
  logic [W-1:0] b_dout;

  int  n_vec = 0;
  int  n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  nx_ram_1r1w_init #(
    .WIDTH(W), .DEPTH(D), .RD_LATENCY(1), .WRITETHROUGH(1'b0), .INIT_VALUE('0)
  ) dut_a (
    .clk(clk), .rst(rst), .init_start(init_start),
    .init_busy(a_busy), .init_done(a_done),
    .reb(reb), .ra(ra), .dout(a_dout), .dout_vld(a_vld),
    .web(web), .wa(wa), .din(din), .bwe(bwe), .addr_err(a_err)
  );

  nx_ram_1r1w_init #(
    .WIDTH(W), .DEPTH(D), .RD_LATENCY(3), .WRITETHROUGH(1'b1), .INIT_VALUE(INIT_B)
  ) dut_b (
    .clk(clk), .rst(rst), .init_start(init_start),
    .init_busy(b_busy), .init_done(b_done),
    .reb(reb), .ra(ra), .dout(b_dout), .dout_vld(b_vld),
    .web(web), .wa(wa), .din(din), .bwe(bwe), .addr_err(b_err)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] mergeWord(input logic [W-1:0] old, input logic [W-1:0] d,
                                             input logic [W-1:0] be);
    return (old & ~be) | (d & be);
  endfunction

  // Behavioural model: phase 0=idle 1=clearing 2=ready; read results are
  // scheduled into a small calendar keyed by the edge they become visible.
  logic [W-1:0] m_mem [2][D];
  int           m_phase [2];
  int           m_cnt [2];
  logic         m_wv [2];
  int           m_wa [2];
  logic [W-1:0] m_wd [2];
  logic [W-1:0] m_wb [2];
  logic         m_sv [2][4];
  logic [W-1:0] m_sd [2][4];
  logic [W-1:0] m_dout [2];
  logic         m_vld [2];
  logic         m_err [2];
  int           m_edge = 0;

  always @(posedge clk) begin
    logic         ready, racc, wacc;
    logic [W-1:0] word;
    int           due, slot, lat;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      if (rst) begin
        m_phase[d] = 0;
        m_cnt[d]   = 0;
        m_wv[d]    = 1'b0;
        for (int s = 0; s < 4; s++) m_sv[d][s] = 1'b0;
        m_dout[d]  = '0;
        m_vld[d]   = 1'b0;
        m_err[d]   = 1'b0;
      end else begin
        ready = (m_phase[d] == 2);
        racc  = ready && !reb;
        wacc  = ready && !web;
        if (racc) begin
          if (int'(ra) >= D) begin
            word = '0;
          end else begin
            word = m_mem[d][ra];
            if (d == 1 && m_wv[d] && m_wa[d] == int'(ra))
              word = mergeWord(m_mem[d][ra], m_wd[d], m_wb[d]);
          end
          due = m_edge + lat - 1;
          m_sv[d][due % 4] = 1'b1;
          m_sd[d][due % 4] = word;
        end
        if (m_wv[d] && m_wa[d] < D)
          m_mem[d][m_wa[d]] = mergeWord(m_mem[d][m_wa[d]], m_wd[d], m_wb[d]);
        m_wv[d] = wacc;
        m_wa[d] = int'(wa);
        m_wd[d] = din;
        m_wb[d] = bwe;
        if (m_phase[d] == 0) begin
          m_phase[d] = 1;
          m_cnt[d]   = 0;
        end else if (m_phase[d] == 1) begin
          m_mem[d][m_cnt[d]] = (d == 0) ? '0 : INIT_B;
          m_cnt[d]++;
          if (m_cnt[d] == D) m_phase[d] = 2;
        end else if (init_start) begin
          m_phase[d] = 1;
          m_cnt[d]   = 0;
        end
        m_err[d] = (racc && int'(ra) >= D) || (wacc && int'(wa) >= D);
        slot = m_edge % 4;
        if (m_sv[d][slot]) begin
          m_vld[d]      = 1'b1;
          m_dout[d]     = m_sd[d][slot];
          m_sv[d][slot] = 1'b0;
        end else begin
          m_vld[d] = 1'b0;
        end
      end
    end
    m_edge++;
  end

  // Compare process: every output of both instances against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("a_busy", a_busy, m_phase[0] == 1);
      checkOutput("a_done", a_done, m_phase[0] == 2);
      checkOutput("a_vld",  a_vld,  m_vld[0]);
      checkOutput("a_dout", a_dout, m_dout[0]);
      checkOutput("a_err",  a_err,  m_err[0]);
      checkOutput("b_busy", b_busy, m_phase[1] == 1);
      checkOutput("b_done", b_done, m_phase[1] == 2);
      checkOutput("b_vld",  b_vld,  m_vld[1]);
      checkOutput("b_dout", b_dout, m_dout[1]);
      checkOutput("b_err",  b_err,  m_err[1]);
    end
  end

  task automatic applyStimulus(input logic r_n, input int r_a, input logic w_n, input int w_a,
                               input logic [W-1:0] d, input logic [W-1:0] be, input logic start);
    reb        = r_n;
    ra         = r_a[7:0];
    web        = w_n;
    wa         = w_a[7:0];
    din        = d;
    bwe        = be;
    init_start = start;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 0, 1'b1, 0, '0, '0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic [W-1:0] be);
    applyStimulus(1'b1, 0, 1'b0, a, d, be, 1'b0);
  endtask

  task automatic rd(input int a);
    applyStimulus(1'b0, a, 1'b1, 0, '0, '0, 1'b0);
  endtask

  // Waits (bounded) for both instances to finish clearing, counting busy cycles;
  // pulses init_start once when A has been busy pulse_at cycles (-1 = never).
  task automatic waitInit(input int pulse_at);
    int ca = 0;
    int cb = 0;
    for (int i = 0; i < 400; i++) begin
      if (a_done && b_done) break;
      applyStimulus(1'b1, 0, 1'b1, 0, '0, '0, (ca == pulse_at));
      if (a_busy) ca++;
      if (b_busy) cb++;
    end
    checkOutput("init_reached_a", a_done, 1'b1);
    checkOutput("init_reached_b", b_done, 1'b1);
    checkOutput("busy_cycles_a", ca, 168);
    checkOutput("busy_cycles_b", cb, 168);
  endtask

  task automatic readAll();
    for (int a = 0; a < D; a++) begin
      rd(a);
      if (a == 100) checkOutput("readall_a_100", a_dout, '0);
      if (a == 102) checkOutput("readall_b_100", b_dout, INIT_B);
    end
    idle(3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    reb = 1'b1; web = 1'b1; ra = '0; wa = '0; din = '0; bwe = '0; init_start = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    checkOutput("rst_a_dout", a_dout, '0);
    checkOutput("rst_a_vld",  a_vld,  1'b0);
    checkOutput("rst_a_busy", a_busy, 1'b0);
    checkOutput("rst_a_done", a_done, 1'b0);
    checkOutput("rst_b_err",  b_err,  1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] initial clear");
    waitInit(-1);
    readAll();

    $display("[TB] write then read, latency 1 and 3");
    wr(7, 83'h5A, ONES);
    idle(1);
    rd(7);
    checkOutput("lat_a_vld", a_vld, 1'b1);
    checkOutput("lat_a_dout", a_dout, 83'h5A);
    checkOutput("lat_b_vld_n", b_vld, 1'b0);
    idle(1);
    checkOutput("lat_b_vld_n1", b_vld, 1'b0);
    checkOutput("hold_a_vld", a_vld, 1'b0);
    checkOutput("hold_a_dout", a_dout, 83'h5A);
    idle(1);
    checkOutput("lat_b_vld_n2", b_vld, 1'b1);
    checkOutput("lat_b_dout", b_dout, 83'h5A);

    $display("[TB] partial write");
    wr(10, 83'hA0, ONES);
    wr(10, 83'hFF, 83'h0F);
    idle(1);
    rd(10);
    checkOutput("bwe_a_dout", a_dout, 83'hAF);
    idle(2);
    checkOutput("bwe_b_dout", b_dout, 83'hAF);

    $display("[TB] read/write collision");
    wr(3, 83'h11, ONES);
    idle(1);
    wr(3, 83'h22, ONES);
    rd(3);
    checkOutput("coll_a_old", a_dout, 83'h11);
    rd(3);
    checkOutput("coll_a_after", a_dout, 83'h22);
    idle(1);
    checkOutput("coll_b_new", b_dout, 83'h22);
    idle(1);
    checkOutput("coll_b_after", b_dout, 83'h22);

    $display("[TB] out-of-range access");
    wr(200, 83'h77, ONES);
    checkOutput("oor_wr_err_a", a_err, 1'b1);
    checkOutput("oor_wr_err_b", b_err, 1'b1);
    idle(1);
    checkOutput("oor_wr_err_drop", a_err, 1'b0);
    rd(200);
    checkOutput("oor_rd_err_a", a_err, 1'b1);
    checkOutput("oor_rd_vld_a", a_vld, 1'b1);
    checkOutput("oor_rd_dout_a", a_dout, '0);
    idle(1);
    checkOutput("oor_rd_err_drop", a_err, 1'b0);
    idle(1);
    checkOutput("oor_rd_dout_b", b_dout, '0);
    idle(2);

    $display("[TB] re-init with pending read, reset mid-clear");
    rd(50);
    applyStimulus(1'b1, 0, 1'b1, 0, '0, '0, 1'b1);
    checkOutput("reinit_busy", a_busy, 1'b1);
    checkOutput("reinit_done", a_done, 1'b0);
    idle(1);
    checkOutput("reinit_b_vld", b_vld, 1'b1);
    checkOutput("reinit_b_dout", b_dout, INIT_B);
    rd(5);
    checkOutput("clear_rd_ignored", a_vld, 1'b0);
    checkOutput("clear_rd_no_err", a_err, 1'b0);
    idle(47);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    waitInit(20);
    readAll();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nx_ram_1r1w_init.md
NX_RAM_1R1W_INIT -- requirements
Module: nx_ram_1r1w_init

Interface
REQ-001 Parameter WIDTH, default 83: data and bit-write-enable width, 1..512.
REQ-002 Parameter DEPTH, default 168: number of words, 2..4096; AW = clog2(DEPTH).
REQ-003 Parameter RD_LATENCY, default 1: cycles from read request to dout_vld, 1..3.
REQ-004 Parameter WRITETHROUGH, default 0: 1 = a read colliding with a committing write returns the merged new data.
REQ-005 Parameter INIT_VALUE, default all zeros, WIDTH bits: word written by the clear sequencer.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 init_start  in  1  pulse that requests a full memory clear; honoured only in DONE.
REQ-009 init_busy  out  1  high while the clear sequencer is running.
REQ-010 init_done  out  1  high when the memory is initialised and user access is enabled.
REQ-011 reb  in  1  active-low read enable.
REQ-012 ra  in  AW  read address.
REQ-013 dout  out  WIDTH  read data.
REQ-014 dout_vld  out  1  dout holds the data for a read issued RD_LATENCY cycles earlier.
REQ-015 web  in  1  active-low write enable.
REQ-016 wa  in  AW  write address.
REQ-017 din  in  WIDTH  write data.
REQ-018 bwe  in  WIDTH  per-bit write enable; 1 = update that bit.
REQ-019 addr_err  out  1  one-cycle pulse when an accepted read or write addresses a word >= DEPTH.

Function
REQ-020 The init FSM shall have states IDLE, CLEAR and DONE; rst forces IDLE, and IDLE moves to CLEAR on the next cycle unconditionally.
REQ-021 CLEAR shall write INIT_VALUE to addresses 0..DEPTH-1, one word per cycle in ascending order, and move to DONE on the cycle after address DEPTH-1 is written (DEPTH cycles in CLEAR).
REQ-022 In DONE, init_start shall move the FSM to CLEAR with the counter reset to 0; init_start outside DONE shall be ignored.
REQ-023 init_busy shall equal (state==CLEAR), and init_done shall equal (state==DONE).
REQ-024 When init_done is low, reb and web shall be ignored: no memory update, no dout_vld and no addr_err.
REQ-025 Writes shall be registered once: web/wa/din/bwe sampled at edge N commit at edge N+1 as mem[wa] = (mem[wa] & ~bwe) | (din & bwe).
REQ-026 A read accepted at edge N shall sample the memory array as it stands before edge N's commit and shall assert dout_vld with data after edge N+RD_LATENCY-1; back-to-back reads shall sustain one result per cycle.
REQ-027 Collision: if a read address equals the address of the write committing on the same edge, dout shall be the merged new word when WRITETHROUGH=1 and the old word when WRITETHROUGH=0.
REQ-028 Writes to addresses >= DEPTH shall be dropped, and reads from them shall return all-zero data with dout_vld asserted; each such access shall pulse addr_err.
REQ-029 A simultaneous read collision and out-of-range access shall follow REQ-028 (zero data).
REQ-030 dout shall hold its last value while dout_vld is low.
REQ-031 An init_start in DONE shall not cancel reads already in the output pipeline; they shall complete with their sampled data.

Reset
REQ-032 On rst: state=IDLE, clear counter=0, init_busy=0, init_done=0, dout=0, dout_vld=0, addr_err=0, and the write-stage valid and every read-pipeline valid cleared.
REQ-033 Array contents shall not be reset; the clear sequence initialises them.
REQ-034 rst asserted during CLEAR shall abort the clear, and the sequence shall restart from address 0.

Structure
REQ-035 Package nx_ram_pkg shall hold the init-state enum (IDLE, CLEAR, DONE), RD_LATENCY_MIN=1 and RD_LATENCY_MAX=3.
REQ-036 The clear sequencer shall be sub-module nx_ram_init_fsm (outputs: state, clear address, clear write strobe); the array, write stage and read pipeline shall live in the top level.
REQ-037 Parameters outside their legal range shall cause an elaboration-time error.

Verification
REQ-038 DEPTH=168, rst for 2 cycles -> init_busy high for exactly 168 cycles, then init_done=1; reading all 168 addresses returns INIT_VALUE.
REQ-039 RD_LATENCY=3 -> write 0x5A to address 7 then read address 7 -> dout_vld high exactly 3 cycles after the read, with dout=0x5A.
REQ-040 Partial write: bwe=0x0F, din=0xFF over a stored 0xA0 -> a read returns 0xAF.
REQ-041 Collision on address 3 (old 0x11, new 0x22) -> WRITETHROUGH=1 returns 0x22 and WRITETHROUGH=0 returns 0x11; a read one cycle later returns 0x22 in both cases.
REQ-042 DEPTH=168: write to address 200, then read address 200 -> addr_err pulses for 1 cycle on each access, the read returns 0, and no in-range word changes.
REQ-043 rst at clear address 50, then init_start issued during CLEAR -> clear restarts at 0, runs 168 cycles, and init_start during CLEAR has no effect.
